mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 16-bit main memory between two requesters: the CPU
//  datapath (port C, fetch/load/stor) and the IO/loader port (port I). Grants
//  at most one access per clock, drives memory address/data/write strobe, and
//  returns read data with a valid pulse. CPU has priority; a streak counter
//  bounds IO starvation. Out-of-range accesses are blocked and flagged.
// PARAMETERS
//  ADDR_W     16   address width of both ports and the memory
//  DATA_W     16   data width
//  MEM_DEPTH  512  implemented words; addr >= MEM_DEPTH is out of range
//  MAX_HOLD   4    max consecutive CPU grants while IO waits (1..15)
// PORTS
//  clock       in   1       system clock, all state on rising edge
//  reset       in   1       asynchronous, active-low reset
//  c_req       in   1       CPU access request (level, held until c_gnt)
//  c_we        in   1       CPU write enable (1 = write, 0 = read)
//  c_addr      in   ADDR_W  CPU word address
//  c_wdata     in   DATA_W  CPU write data
//  c_gnt       out  1       CPU granted this cycle (combinational)
//  c_rvalid    out  1       CPU read data valid (registered)
//  i_req/i_we/i_addr/i_wdata  in   1/1/ADDR_W/DATA_W  IO port, same as CPU
//  i_gnt       out  1       IO granted this cycle (combinational)
//  i_rvalid    out  1       IO read data valid (registered)
//  rdata       out  DATA_W  read data for whichever rvalid is high, else 0
//  addr_err    out  1       1-cycle pulse: granted access was out of range
//  mem_address out  ADDR_W  to memory Address
//  mem_data_in out  DATA_W  to memory DataIn
//  mem_write   out  1       to memory MemWrite
//  mem_val     in   DATA_W  from memory MemVal (registered, 1-cycle latency)
// BEHAVIOUR
//  - Reset (reset=0): streak=0, c_rvalid=i_rvalid=addr_err=0, pending response
//    discarded; mem_write forced 0 while reset low; memory contents untouched.
//  - Grant (combinational, cycle N): only c_req -> C; only i_req -> I; both ->
//    C unless streak==MAX_HOLD, then I. No req -> no grant, mem_write=0.
//  - Streak: both req and C granted -> streak+1; I granted or i_req low -> 0.
//    Never exceeds MAX_HOLD.
//  - Granted port's addr/wdata drive mem_address/mem_data_in; mem_write =
//    granted we & in-range. With no grant, mem_address holds CPU c_addr, wdata 0.
//  - Read latency: read granted in cycle N -> owner's rvalid=1 in N+1, rdata =
//    mem_val. Exactly one rvalid per granted read; writes produce no rvalid.
//  - Out of range (addr >= MEM_DEPTH): grant still given (counts for streak),
//    write suppressed, read returns rvalid with rdata=0; addr_err=1 in N+1.
//  - Back-to-back: a new grant may issue every cycle; response of N and grant
//    of N+1 coexist. Requester changes addr only after seeing its gnt.
//  - Write then read same address on consecutive cycles returns new data.
//  - Reset asserted between grant and response: response never appears.
// TESTING
//  1 CPU write 0x1234 @5, then read @5 -> c_rvalid next cycle, rdata=0x1234.
//  2 c_req,i_req held high 12 cycles, MAX_HOLD=4 -> grants CCCCI CCCCI CC;
//    I read @7 after loader write 0xBEEF -> i_rvalid, rdata=0xBEEF.
//  3 Single read each cycle alternating C/I to @1,@2 (0x0011,0x0022) -> rvalid
//    alternates, rdata matches, no gaps.
//  4 CPU write 0xFFFF @600 -> mem_write=0, addr_err pulse; read @600 ->
//    c_rvalid, rdata=0, addr_err pulse; @511 access normal.
//  5 Grant read @3, drop reset before next edge -> no c_rvalid, streak=0,
//    mem_write=0 until reset released; memory @3 unchanged.
//  6 No requests for 10 cycles -> no gnt, no rvalid, mem_write=0, streak=0.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the CPU/IO requesters, the arbiter and the single-port main memory.
// The arbiter uses the slave view; requesters and the memory model use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;

  logic              i_req;
  logic              i_we;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata;
  logic              i_gnt;
  logic              i_rvalid;

  logic [DATA_W-1:0] rdata;
  logic              addr_err;

  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_write;
  logic [DATA_W-1:0] mem_val;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  i_req, i_we, i_addr, i_wdata,
    input  mem_val,
    output c_gnt, c_rvalid, i_gnt, i_rvalid,
    output rdata, addr_err,
    output mem_address, mem_data_in, mem_write
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output i_req, i_we, i_addr, i_wdata,
    output mem_val,
    input  c_gnt, c_rvalid, i_gnt, i_rvalid,
    input  rdata, addr_err,
    input  mem_address, mem_data_in, mem_write
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for the single-port main memory: CPU has priority, a streak
// counter guarantees the IO port a slot, out-of-range accesses are blocked and flagged.
module mem_port_arbiter #(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 512,
  parameter int unsigned MAX_HOLD  = 4
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_IO   = 2'd2
  } owner_e;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

  owner_e            w_gnt_owner;
  logic              w_we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic              w_in_range;

  logic [3:0]        r_streak;
  logic [3:0]        w_streak_nxt;
  owner_e            r_resp_owner;
  owner_e            w_resp_owner_nxt;
  logic              r_resp_oor;
  logic              w_resp_oor_nxt;
  logic              r_addr_err;
  logic              w_addr_err_nxt;

  // Grants are withheld while reset is low so a requester never sees a grant that is discarded.
  always_comb begin
    w_gnt_owner = OWN_NONE;
    if (reset) begin
      if (bus.c_req && bus.i_req) begin
        w_gnt_owner = (r_streak == HOLD_LIMIT) ? OWN_IO : OWN_CPU;
      end else if (bus.c_req) begin
        w_gnt_owner = OWN_CPU;
      end else if (bus.i_req) begin
        w_gnt_owner = OWN_IO;
      end
    end
  end

  always_comb begin
    w_we    = 1'b0;
    w_addr  = bus.c_addr;
    w_wdata = '0;
    case (w_gnt_owner)
      OWN_CPU: begin
        w_we    = bus.c_we;
        w_addr  = bus.c_addr;
        w_wdata = bus.c_wdata;
      end
      OWN_IO: begin
        w_we    = bus.i_we;
        w_addr  = bus.i_addr;
        w_wdata = bus.i_wdata;
      end
      default: begin
      end
    endcase
  end

  assign w_in_range = (32'(w_addr) < MEM_DEPTH);

  always_comb begin
    w_streak_nxt     = 4'd0;
    w_resp_owner_nxt = OWN_NONE;
    w_resp_oor_nxt   = 1'b0;
    w_addr_err_nxt   = 1'b0;
    if (w_gnt_owner == OWN_CPU && bus.i_req) begin
      w_streak_nxt = (r_streak == HOLD_LIMIT) ? r_streak : r_streak + 4'd1;
    end
    if (w_gnt_owner != OWN_NONE) begin
      if (!w_we) begin
        w_resp_owner_nxt = w_gnt_owner;
        w_resp_oor_nxt   = !w_in_range;
      end
      w_addr_err_nxt = !w_in_range;
    end
  end

  // Response state tracks the access granted last cycle; reset drops any in-flight read.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_streak     <= 4'd0;
      r_resp_owner <= OWN_NONE;
      r_resp_oor   <= 1'b0;
      r_addr_err   <= 1'b0;
    end else begin
      r_streak     <= w_streak_nxt;
      r_resp_owner <= w_resp_owner_nxt;
      r_resp_oor   <= w_resp_oor_nxt;
      r_addr_err   <= w_addr_err_nxt;
    end
  end

  assign bus.c_gnt       = (w_gnt_owner == OWN_CPU);
  assign bus.i_gnt       = (w_gnt_owner == OWN_IO);
  assign bus.mem_address = w_addr;
  assign bus.mem_data_in = w_wdata;
  assign bus.mem_write   = reset && (w_gnt_owner != OWN_NONE) && w_we && w_in_range;

  assign bus.c_rvalid    = (r_resp_owner == OWN_CPU);
  assign bus.i_rvalid    = (r_resp_owner == OWN_IO);
  assign bus.rdata       = ((r_resp_owner != OWN_NONE) && !r_resp_oor) ? bus.mem_val : '0;
  assign bus.addr_err    = r_addr_err;

endmodule
